// File: rtl/move_sequencer.sv
// Turn/move controller feeding the win checker: validates requests, commits them
// to the board, waits WIN_LATENCY cycles for the win result, then alternates turns or ends the game.
module move_sequencer #(
  parameter int BOARD_SIZE  = 10,
  parameter int WIN_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_x,
  input  logic [3:0] move_y,
  output logic       move_ready,
  output logic       move_err,
  output logic [3:0] recent_x,
  output logic [3:0] recent_y,
  output logic [1:0] piece_type,
  output logic       check_busy,
  input  logic       win,
  output logic [1:0] turn,
  output logic [6:0] move_count,
  output logic       game_over,
  output logic [1:0] winner,
  input  logic [3:0] rd_x,
  input  logic [3:0] rd_y,
  output logic [1:0] rd_piece
);

  localparam int         CELLS = BOARD_SIZE * BOARD_SIZE;
  localparam int         IDX_W = $clog2(CELLS);
  localparam int         LAT_W = $clog2(WIN_LATENCY + 1);
  localparam logic [3:0] BS    = 4'(BOARD_SIZE);

  typedef enum logic [1:0] {IDLE, CHECK, OVER} state_t;

  state_t           state;
  logic [1:0]       board [CELLS];
  logic [LAT_W-1:0] lat_cnt;
  logic [IDX_W-1:0] mv_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             mv_in_range;
  logic             rd_in_range;
  logic             mv_free;

  function automatic logic [IDX_W-1:0] cell_index(input logic [3:0] x, input logic [3:0] y);
    return IDX_W'(int'(y) * BOARD_SIZE + int'(x));
  endfunction

  assign mv_in_range = (move_x < BS) && (move_y < BS);
  assign rd_in_range = (rd_x < BS) && (rd_y < BS);
  assign mv_idx      = cell_index(move_x, move_y);
  assign rd_idx      = cell_index(rd_x, rd_y);
  assign mv_free     = (board[mv_idx] == 2'b00);
  assign rd_piece    = rd_in_range ? board[rd_idx] : 2'b00;

  assign move_ready  = (state == IDLE);
  assign check_busy  = (state == CHECK);
  assign game_over   = (state == OVER);

  // new_game mirrors the reset clear and wins over any move presented in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) board[i] <= 2'b00;
      state      <= IDLE;
      turn       <= 2'b01;
      move_count <= '0;
      recent_x   <= '0;
      recent_y   <= '0;
      piece_type <= 2'b00;
      winner     <= 2'b00;
      move_err   <= 1'b0;
      lat_cnt    <= '0;
    end else if (new_game) begin
      for (int i = 0; i < CELLS; i++) board[i] <= 2'b00;
      state      <= IDLE;
      turn       <= 2'b01;
      move_count <= '0;
      recent_x   <= '0;
      recent_y   <= '0;
      piece_type <= 2'b00;
      winner     <= 2'b00;
      move_err   <= 1'b0;
      lat_cnt    <= '0;
    end else begin
      move_err <= 1'b0;
      case (state)
        IDLE: begin
          if (move_valid) begin
            if (mv_in_range && mv_free) begin
              board[mv_idx] <= turn;
              recent_x      <= move_x;
              recent_y      <= move_y;
              piece_type    <= turn;
              move_count    <= move_count + 7'd1;
              lat_cnt       <= LAT_W'(WIN_LATENCY);
              state         <= CHECK;
            end else begin
              move_err <= 1'b1;
            end
          end
        end
        CHECK: begin
          // The win result is valid on the last cycle of the latency window.
          if (lat_cnt == LAT_W'(1)) begin
            if (win) begin
              winner <= piece_type;
              state  <= OVER;
            end else if (move_count == 7'(CELLS)) begin
              winner <= 2'b00;
              state  <= OVER;
            end else begin
              turn  <= {turn[0], turn[1]};
              state <= IDLE;
            end
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        OVER: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
